// File: rtl/cell_grid_if.sv
// Handshake/bus bundle between the cursor/KEY side and the cell grid editor.
// Carries edit requests, bulk load, and the registered grid status outputs.
interface cell_grid_if #(
  parameter int unsigned ROWS = 16,
  parameter int unsigned COLS = 16
);
  localparam int unsigned RW = $clog2(ROWS);
  localparam int unsigned CW = $clog2(COLS);
  localparam int unsigned NW = $clog2(ROWS * COLS + 1);
  localparam int unsigned N  = ROWS * COLS;

  logic          key_n;
  logic [1:0]    mode;
  logic [RW-1:0] row_sel;
  logic [CW-1:0] col_sel;
  logic          lock;
  logic          clear_all;
  logic          load;
  logic [N-1:0]  load_data;
  logic [N-1:0]  grid;
  logic          busy;
  logic          edit_done;
  logic [NW-1:0] alive_count;

  modport master (
    output key_n, mode, row_sel, col_sel, lock, clear_all, load, load_data,
    input  grid, busy, edit_done, alive_count
  );

  modport slave (
    input  key_n, mode, row_sel, col_sel, lock, clear_all, load, load_data,
    output grid, busy, edit_done, alive_count
  );
endinterface

// File: rtl/cell_grid_editor.sv
// Cell grid register with single-cell edits on button press, row-by-row
// clear sweep, bulk load from the automaton engine and a registered live count.
module cell_grid_editor #(
  parameter int unsigned ROWS = 16,
  parameter int unsigned COLS = 16
) (
  input logic     clk,
  input logic     reset,
  cell_grid_if.slave bus
);
  localparam int unsigned RW = $clog2(ROWS);
  localparam int unsigned CW = $clog2(COLS);
  localparam int unsigned NW = $clog2(ROWS * COLS + 1);
  localparam int unsigned N  = ROWS * COLS;
  localparam int unsigned IW = $clog2(N);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t        state;
  logic          key_q;
  logic [RW-1:0] sweep_row;
  logic [N-1:0]  grid_q;
  logic          busy_q;
  logic          edit_done_q;
  logic [NW-1:0] alive_q;

  logic          press;
  logic          in_range;
  logic [IW-1:0] idx;
  logic [IW-1:0] row_shift;
  logic [N-1:0]  cell_mask;
  logic [N-1:0]  row_mask;
  logic [N-1:0]  edit_val;
  logic [NW-1:0] pop;

  // Edit target decode, sweep row mask and popcount of the current grid.
  always_comb begin
    press     = key_q & ~bus.key_n;
    in_range  = ({1'b0, bus.row_sel} < (RW + 1)'(ROWS)) &&
                ({1'b0, bus.col_sel} < (CW + 1)'(COLS));
    idx       = IW'(bus.row_sel) * IW'(COLS) + IW'(bus.col_sel);
    row_shift = IW'(sweep_row) * IW'(COLS);
    cell_mask = N'(1) << idx;
    row_mask  = N'({COLS{1'b1}}) << row_shift;
    case (bus.mode)
      2'b00:   edit_val = grid_q | cell_mask;
      2'b01:   edit_val = grid_q & ~cell_mask;
      2'b10:   edit_val = grid_q ^ cell_mask;
      default: edit_val = grid_q;
    endcase
    pop = '0;
    for (int i = 0; i < int'(N); i++) begin
      pop = pop + NW'(grid_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      key_q       <= 1'b1;
      sweep_row   <= '0;
      grid_q      <= '0;
      busy_q      <= 1'b0;
      edit_done_q <= 1'b0;
      alive_q     <= '0;
    end else begin
      key_q       <= bus.key_n;
      edit_done_q <= 1'b0;
      alive_q     <= pop;
      case (state)
        IDLE: begin
          // clear_all beats load beats press; losers are dropped.
          if (bus.clear_all && !bus.lock) begin
            state     <= CLEAR;
            busy_q    <= 1'b1;
            sweep_row <= '0;
          end else if (bus.load) begin
            grid_q      <= bus.load_data;
            edit_done_q <= 1'b1;
          end else if (press && !bus.lock && in_range && bus.mode != 2'b11) begin
            grid_q      <= edit_val;
            edit_done_q <= 1'b1;
          end
        end
        CLEAR: begin
          grid_q <= grid_q & ~row_mask;
          if (sweep_row == RW'(ROWS - 1)) begin
            state       <= IDLE;
            busy_q      <= 1'b0;
            edit_done_q <= 1'b1;
          end else begin
            sweep_row <= sweep_row + RW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grid        = grid_q;
  assign bus.busy        = busy_q;
  assign bus.edit_done   = edit_done_q;
  assign bus.alive_count = alive_q;
endmodule

// File: tb/tb_cell_grid_editor.sv
// Directed bench for cell_grid_editor: 16x16 main instance plus a 10x12
// instance for the non-power-of-two range check.
module tb_cell_grid_editor;
  logic clk;
  logic reset;
  int   tests;
  int   fails;

  cell_grid_if #(.ROWS(16), .COLS(16)) b ();
  cell_grid_if #(.ROWS(10), .COLS(12)) s ();

  cell_grid_editor #(.ROWS(16), .COLS(16)) dut (.clk(clk), .reset(reset), .bus(b));
  cell_grid_editor #(.ROWS(10), .COLS(12)) dut_s (.clk(clk), .reset(reset), .bus(s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (b.grid !== '0 || b.busy !== 1'b0 || b.edit_done !== 1'b0 || b.alive_count !== 9'd0) begin
      fails++;
      $display("FAIL reset: grid=%0h busy=%b done=%b alive=%0d, required 0/0/0/0",
               b.grid, b.busy, b.edit_done, b.alive_count);
    end
  endtask

  task automatic test_press_set();
    int pulses;
    b.mode = 2'b00; b.row_sel = 4'd1; b.col_sel = 4'd5;
    b.key_n = 1'b0;
    tick();
    tests++;
    if (b.grid[21] !== 1'b1 || b.edit_done !== 1'b1 || b.alive_count !== 9'd0) begin
      fails++;
      $display("FAIL set_press: bit21=%b done=%b alive=%0d, required 1/1/0",
               b.grid[21], b.edit_done, b.alive_count);
    end
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) begin
        tests++;
        if (b.alive_count !== 9'd1) begin
          fails++;
          $display("FAIL alive_lag: alive=%0d, required 1", b.alive_count);
        end
      end
      if (b.edit_done === 1'b1) pulses++;
    end
    tests++;
    if (pulses != 0) begin
      fails++;
      $display("FAIL hold_no_repeat: pulses=%0d, required 0", pulses);
    end
    b.key_n = 1'b1;
    tick();
    // set on an already-set cell still pulses
    b.key_n = 1'b0;
    tick();
    tests++;
    if (b.edit_done !== 1'b1 || b.grid !== 256'd1 << 21) begin
      fails++;
      $display("FAIL set_on_one: done=%b grid=%0h, required 1/%0h", b.edit_done, b.grid, 256'd1 << 21);
    end
    b.key_n = 1'b1; b.mode = 2'b11;
    tick();
    b.key_n = 1'b0;
    tick();
    tests++;
    if (b.edit_done !== 1'b0 || b.grid !== 256'd1 << 21) begin
      fails++;
      $display("FAIL noop_mode: done=%b grid=%0h, required 0/%0h", b.edit_done, b.grid, 256'd1 << 21);
    end
    b.key_n = 1'b1; b.mode = 2'b01;
    tick();
    b.key_n = 1'b0;
    tick();
    tests++;
    if (b.edit_done !== 1'b1 || b.grid !== '0) begin
      fails++;
      $display("FAIL clear_mode: done=%b grid=%0h, required 1/0", b.edit_done, b.grid);
    end
    b.key_n = 1'b1;
    tick();
  endtask

  task automatic test_toggle();
    do_reset();
    b.mode = 2'b10; b.row_sel = 4'd15; b.col_sel = 4'd0;
    b.key_n = 1'b0;
    tick();
    tests++;
    if (b.grid[240] !== 1'b1 || b.edit_done !== 1'b1) begin
      fails++;
      $display("FAIL toggle_on: bit240=%b done=%b, required 1/1", b.grid[240], b.edit_done);
    end
    b.key_n = 1'b1;
    tick();
    tests++;
    if (b.alive_count !== 9'd1 || b.edit_done !== 1'b0) begin
      fails++;
      $display("FAIL toggle_count: alive=%0d done=%b, required 1/0", b.alive_count, b.edit_done);
    end
    b.key_n = 1'b0;
    tick();
    tests++;
    if (b.grid[240] !== 1'b0 || b.edit_done !== 1'b1) begin
      fails++;
      $display("FAIL toggle_off: bit240=%b done=%b, required 0/1", b.grid[240], b.edit_done);
    end
    b.key_n = 1'b1;
    tick();
    tests++;
    if (b.alive_count !== 9'd0) begin
      fails++;
      $display("FAIL toggle_count0: alive=%0d, required 0", b.alive_count);
    end
  endtask

  task automatic test_lock_load();
    b.lock = 1'b1; b.mode = 2'b00; b.row_sel = 4'd3; b.col_sel = 4'd3;
    b.key_n = 1'b0;
    tick();
    tests++;
    if (b.grid !== '0 || b.edit_done !== 1'b0) begin
      fails++;
      $display("FAIL lock_press: grid=%0h done=%b, required 0/0", b.grid, b.edit_done);
    end
    b.key_n = 1'b1;
    tick();
    b.key_n = 1'b0; b.load = 1'b1; b.load_data = '1;
    tick();
    tests++;
    if (b.grid !== {256{1'b1}} || b.edit_done !== 1'b1) begin
      fails++;
      $display("FAIL lock_load: grid=%0h done=%b, required all ones/1", b.grid, b.edit_done);
    end
    b.load = 1'b0; b.key_n = 1'b1; b.lock = 1'b0;
    tick();
    tests++;
    if (b.alive_count !== 9'd256) begin
      fails++;
      $display("FAIL load_count: alive=%0d, required 256", b.alive_count);
    end
  endtask

  task automatic test_clear_sweep();
    logic [15:0] row_v;
    int busy_cycles;
    b.clear_all = 1'b1;
    tick();
    b.clear_all = 1'b0;
    busy_cycles = (b.busy === 1'b1) ? 1 : 0;
    tests++;
    if (b.busy !== 1'b1 || b.grid !== {256{1'b1}}) begin
      fails++;
      $display("FAIL clear_start: busy=%b grid=%0h, required 1/all ones", b.busy, b.grid);
    end
    for (int k = 0; k < 16; k++) begin
      if (k == 3) begin
        b.mode = 2'b00; b.row_sel = 4'd3; b.col_sel = 4'd3; b.key_n = 1'b0;
      end
      tick();
      if (b.busy === 1'b1) busy_cycles++;
      row_v = b.grid[k*16 +: 16];
      tests++;
      if (row_v !== 16'h0) begin
        fails++;
        $display("FAIL sweep_row%0d: row=%0h, required 0", k, row_v);
      end
      if (k < 15) begin
        row_v = b.grid[(k+1)*16 +: 16];
        tests++;
        if (row_v !== 16'hffff || b.edit_done !== 1'b0) begin
          fails++;
          $display("FAIL sweep_next%0d: row=%0h done=%b, required ffff/0", k, row_v, b.edit_done);
        end
      end else begin
        tests++;
        if (b.edit_done !== 1'b1 || b.busy !== 1'b0) begin
          fails++;
          $display("FAIL sweep_end: done=%b busy=%b, required 1/0", b.edit_done, b.busy);
        end
      end
    end
    tests++;
    if (busy_cycles != 16) begin
      fails++;
      $display("FAIL busy_len: cycles=%0d, required 16", busy_cycles);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (b.edit_done !== 1'b0 || b.grid !== '0 || b.alive_count !== 9'd0) begin
        fails++;
        $display("FAIL after_sweep%0d: done=%b grid=%0h alive=%0d, required 0/0/0",
                 i, b.edit_done, b.grid, b.alive_count);
      end
    end
    b.key_n = 1'b1;
    tick();
  endtask

  task automatic test_simultaneous();
    b.load = 1'b1; b.load_data = '1;
    tick();
    b.load_data = 256'h00a5; b.clear_all = 1'b1;
    b.mode = 2'b01; b.row_sel = 4'd0; b.col_sel = 4'd0; b.key_n = 1'b0;
    tick();
    b.load = 1'b0; b.clear_all = 1'b0; b.key_n = 1'b1;
    tests++;
    if (b.busy !== 1'b1 || b.grid !== {256{1'b1}} || b.edit_done !== 1'b0) begin
      fails++;
      $display("FAIL simul_clear_wins: busy=%b grid=%0h done=%b, required 1/all ones/0",
               b.busy, b.grid, b.edit_done);
    end
    for (int k = 0; k < 7; k++) tick();
    tests++;
    if (b.grid[127:112] !== 16'hffff || b.grid[111:0] !== '0) begin
      fails++;
      $display("FAIL sweep7_state: grid=%0h, required rows 0-6 zero, row7 ffff", b.grid);
    end
    do_reset();
    tests++;
    if (b.grid !== '0 || b.busy !== 1'b0 || b.edit_done !== 1'b0 || b.alive_count !== 9'd0) begin
      fails++;
      $display("FAIL midsweep_reset: grid=%0h busy=%b done=%b alive=%0d, required 0/0/0/0",
               b.grid, b.busy, b.edit_done, b.alive_count);
    end
    b.mode = 2'b00; b.row_sel = 4'd0; b.col_sel = 4'd0; b.key_n = 1'b0;
    tick();
    tests++;
    if (b.grid !== 256'd1 || b.edit_done !== 1'b1 || b.busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: grid=%0h done=%b busy=%b, required 1/1/0",
               b.grid, b.edit_done, b.busy);
    end
    b.key_n = 1'b1;
    tick();
  endtask

  task automatic test_small_grid();
    s.mode = 2'b00; s.row_sel = 4'd9; s.col_sel = 4'd11; s.key_n = 1'b0;
    tick();
    tests++;
    if (s.grid !== 120'd1 << 119 || s.edit_done !== 1'b1) begin
      fails++;
      $display("FAIL small_corner: grid=%0h done=%b, required %0h/1", s.grid, s.edit_done, 120'd1 << 119);
    end
    s.key_n = 1'b1; s.row_sel = 4'd12; s.col_sel = 4'd0;
    tick();
    s.key_n = 1'b0;
    tick();
    tests++;
    if (s.grid !== 120'd1 << 119 || s.edit_done !== 1'b0) begin
      fails++;
      $display("FAIL small_row_oor: grid=%0h done=%b, required %0h/0", s.grid, s.edit_done, 120'd1 << 119);
    end
    s.key_n = 1'b1; s.row_sel = 4'd0; s.col_sel = 4'd12;
    tick();
    s.key_n = 1'b0;
    tick();
    tests++;
    if (s.grid !== 120'd1 << 119 || s.edit_done !== 1'b0) begin
      fails++;
      $display("FAIL small_col_oor: grid=%0h done=%b, required %0h/0", s.grid, s.edit_done, 120'd1 << 119);
    end
    s.key_n = 1'b1;
    tick();
    tests++;
    if (s.alive_count !== 7'd1) begin
      fails++;
      $display("FAIL small_count: alive=%0d, required 1", s.alive_count);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0;
    b.key_n = 1'b1; b.mode = 2'b11; b.row_sel = '0; b.col_sel = '0;
    b.lock = 1'b0; b.clear_all = 1'b0; b.load = 1'b0; b.load_data = '0;
    s.key_n = 1'b1; s.mode = 2'b11; s.row_sel = '0; s.col_sel = '0;
    s.lock = 1'b0; s.clear_all = 1'b0; s.load = 1'b0; s.load_data = '0;
    tick();
    test_reset();
    test_press_set();
    test_toggle();
    test_lock_load();
    test_clear_sweep();
    test_simultaneous();
    test_small_grid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cell_grid_editor.md
Name: cell_grid_editor

Overview:
Parametrised editor for the cellular-automaton cell grid. Registers the grid and applies single-cell edits at the selected (row, col) on each debounced, active-low button press, in set, clear or toggle mode. Also provides a multi-cycle clear-all sweep, a bulk load port for the automaton engine, an edit lock, and a registered live-cell count. It sits between the cursor counters / KEY input and the automaton engine / LED-matrix driver.

Parameters:
ROWS, 16, grid rows (>=2)
COLS, 16, grid columns (>=2)
RW, $clog2(ROWS), row index width (derived)
CW, $clog2(COLS), column index width (derived)
NW, $clog2(ROWS*COLS+1), live-count width (derived)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
key_n  in  1  edit button, active-low, already synchronised/debounced
mode  in  2  edit op: 00 set, 01 clear, 10 toggle, 11 no-op
row_sel  in  RW  cursor row
col_sel  in  CW  cursor column
lock  in  1  1 = edits and clear_all ignored (automaton running)
clear_all  in  1  one-cycle request to zero the grid
load  in  1  one-cycle bulk-load strobe
load_data  in  ROWS*COLS  bulk grid value, bit r*COLS+c = cell (r,c)
grid  out  ROWS*COLS  current grid, bit r*COLS+c = cell (r,c)
busy  out  1  high while clear sweep in progress
edit_done  out  1  one-cycle pulse when grid changed by edit, clear or load
alive_count  out  NW  number of 1 bits in grid

Behaviour:
- Reset (synchronous, any state, including mid-sweep):
  - grid=0, busy=0, edit_done=0, alive_count=0.
  - State goes to IDLE; key history register = 1 (released).
- Press detect: key_q is key_n delayed one cycle. press = key_q & ~key_n.
  - One press per falling edge; holding never repeats.
- FSM states: IDLE, CLEAR.
- IDLE priority within one cycle: clear_all (if !lock) > load > press (if !lock).
  - Lower-priority events in the same cycle are dropped, not queued.
- Edit on press:
  - Target bit = row_sel*COLS + col_sel.
  - Applied at the next clk edge; visible in grid and edit_done=1 in the cycle after press is sampled.
  - set writes 1, clear writes 0, toggle inverts.
  - mode 11: no grid change, no edit_done.
  - Target already at the written value (e.g. set on a 1): still pulses edit_done.
- Out-of-range select (row_sel>=ROWS or col_sel>=COLS, non-power-of-2 sizes only): press ignored, no edit_done.
- Load: grid <= load_data at next edge; edit_done pulses. Accepted regardless of lock.
- clear_all: IDLE -> CLEAR.
  - busy=1 from the next cycle.
  - Zeroes row k on the k-th CLEAR cycle, k=0..ROWS-1, so the sweep takes exactly ROWS cycles.
  - After the row ROWS-1 write: edit_done pulses, busy=0, return to IDLE.
- In CLEAR: presses, load and clear_all are all ignored; key_q still tracks key_n.
  - A key held down across the end of the sweep does not fire.
- alive_count: registered popcount of grid; lags grid by exactly one cycle.
  - Maximum value ROWS*COLS must fit in NW bits.
- grid and edit_done are registered outputs; no combinational path from inputs to outputs.

Test Plan:
- Reset, ROWS=COLS=16: assert reset 1 cycle -> grid=0, busy=0, alive_count=0. Drive key_n 1->0 with mode=00, row=1, col=5 -> bit 21 =1, edit_done 1 cycle, alive_count=1 one cycle later. Hold key_n=0 for 5 cycles -> no further edit_done.
- Toggle: mode=10, row=15, col=0, press twice (release between) -> bit 240 goes 1 then 0. edit_done pulses twice; alive_count returns to 0.
- Lock: lock=1, press with mode=00 at (3,3) -> grid unchanged, no edit_done. Same cycle load=1, load_data all 1s -> grid all 1s, alive_count=256.
- Clear sweep: grid all 1s, clear_all=1 -> busy high exactly 16 cycles. Row k reads zero after sweep cycle k. edit_done at end; alive_count=0. A press during busy has no effect.
- Simultaneous: clear_all, load and press in the same IDLE cycle -> clear wins and load is dropped. Reset asserted at sweep cycle 7 -> grid=0, busy=0 next cycle, FSM in IDLE.
- ROWS=10, COLS=12 build: press at (9,11) -> bit 119 set. row_sel=12 -> ignored, no edit_done.
